// File: rtl/logic_gate_unit_pkg.sv
// Shared definitions for the switch-driven gate unit: op encodings and the
// gate reduction, kept here so later ALU labs can reuse it.
package logic_gate_unit_pkg;

  localparam int MAX_IN = 8;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_BUF  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  // Only the low n bits take part, so callers may zero-extend narrower vectors.
  function automatic logic gate_reduce(input logic [2:0] op,
                                       input logic [MAX_IN-1:0] bits,
                                       input int n);
    logic all1, any1, par, res;
    all1 = 1'b1;
    any1 = 1'b0;
    par  = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        all1 = all1 & bits[i];
        any1 = any1 | bits[i];
        par  = par ^ bits[i];
      end
    end
    case (op)
      OP_AND:  res = all1;
      OP_OR:   res = any1;
      OP_XOR:  res = par;
      OP_NAND: res = ~all1;
      OP_NOR:  res = ~any1;
      OP_XNOR: res = ~par;
      OP_BUF:  res = bits[0];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_gate_unit_switch_debounce.sv
// One switch input: two-flop synchroniser followed by a mismatch counter that
// accepts a new level only after DEB_CYCLES consecutive disagreeing cycles.
module switch_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle agreeing with the accepted level restarts the count, so bounce is dropped.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/logic_gate_unit.sv
// Debounced switch bank combined by a runtime-selectable gate into a
// registered LED plus a one-cycle change pulse.
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] sw_i,
  input  logic [2:0]      op_i,
  output logic [N_IN-1:0] stable_o,
  output logic            led_o,
  output logic            changed_o
);

  logic [MAX_IN-1:0] stable_ext;
  logic              led_q, led_d;
  logic              changed_q, changed_d;

  for (genvar k = 0; k < N_IN; k++) begin : g_deb
    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_i     (sw_i[k]),
      .stable_o (stable_o[k])
    );
  end

  assign stable_ext = MAX_IN'(stable_o);

  always_comb begin
    led_d     = gate_reduce(op_i, stable_ext, N_IN);
    changed_d = (led_d != led_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      changed_q <= changed_d;
    end
  end

  assign led_o     = led_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench: stimulus queues expected stable_o changes and changed_o
// pulses (with their edge numbers); monitors pop and compare on each event.
module tb_logic_gate_unit;
  import logic_gate_unit_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw_n = 2'b11;
  logic [2:0] op_n = OP_AND;
  logic [1:0] stable_n;
  logic       led_n, chg_n;
  logic [3:0] sw_w = 4'b0000;
  logic [2:0] op_w = OP_XOR;
  logic [3:0] stable_w;
  logic       led_w, chg_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  ev_t sq_n[$], lq_n[$], sq_w[$], lq_w[$];
  logic [1:0] prev_n;
  logic [3:0] prev_w;

  logic_gate_unit #(.N_IN(2), .DEB_CYCLES(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .sw_i(sw_n), .op_i(op_n),
    .stable_o(stable_n), .led_o(led_n), .changed_o(chg_n)
  );

  logic_gate_unit #(.N_IN(4), .DEB_CYCLES(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .sw_i(sw_w), .op_i(op_w),
    .stable_o(stable_w), .led_o(led_w), .changed_o(chg_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  task automatic sb_cmp(input string name, input ev_t e, input logic [7:0] act);
    n_cmp++;
    if (act !== e.val || cyc != e.cyc) begin
      n_bad++;
      $display("FAIL %s: got %b at edge %0d, expected %b at edge %0d",
               name, act, cyc, e.val, e.cyc);
    end
  endtask

  task automatic sb_unexp(input string name, input logic [7:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event value %b at edge %0d", name, act, cyc);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_n = stable_n;
    end else begin
      if (stable_n != prev_n) begin
        if (sq_n.size() == 0) sb_unexp("stable_n", 8'(stable_n));
        else sb_cmp("stable_n", sq_n.pop_front(), 8'(stable_n));
        prev_n = stable_n;
      end
      if (chg_n) begin
        if (lq_n.size() == 0) sb_unexp("led_n", 8'(led_n));
        else sb_cmp("led_n", lq_n.pop_front(), 8'(led_n));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_w = stable_w;
    end else begin
      if (stable_w != prev_w) begin
        if (sq_w.size() == 0) sb_unexp("stable_w", 8'(stable_w));
        else sb_cmp("stable_w", sq_w.pop_front(), 8'(stable_w));
        prev_w = stable_w;
      end
      if (chg_w) begin
        if (lq_w.size() == 0) sb_unexp("led_w", 8'(led_w));
        else sb_cmp("led_w", lq_w.pop_front(), 8'(led_w));
      end
    end
  end

  initial begin
    int   e0;
    logic model_led;
    logic tt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with switches high under AND
    repeat (3) step();
    chk("rst_stable", 8'(stable_n), 8'h00);
    chk("rst_led", 8'(led_n), 8'h00);
    chk("rst_changed", 8'(chg_n), 8'h00);
    rst_n = 1'b1;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b11));
    lq_n.push_back(mk(e0 + 6, 8'h01));
    repeat (10) step();

    // Settle to 00 under OR, then a 3-cycle bounce on bit 0
    sw_n = 2'b00;
    op_n = OP_OR;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b00));
    lq_n.push_back(mk(e0 + 6, 8'h00));
    repeat (10) step();
    sw_n = 2'b01;
    repeat (3) step();
    sw_n = 2'b00;
    repeat (10) step();
    chk("bounce_stable", 8'(stable_n), 8'h00);
    chk("bounce_led", 8'(led_n), 8'h00);

    // Truth table over stable 10
    sw_n = 2'b10;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b10));
    lq_n.push_back(mk(e0 + 6, 8'h01));
    repeat (10) step();
    model_led = 1'b1;
    for (int v = 0; v < 8; v++) begin
      op_n = 3'(v);
      if (tt[v] != model_led) lq_n.push_back(mk(cyc + 1, 8'(tt[v])));
      model_led = tt[v];
      step();
      chk($sformatf("tt_op%0d", v), 8'(led_n), 8'(tt[v]));
    end

    // Simultaneous change 00 -> 11 under AND
    op_n = OP_AND;
    sw_n = 2'b00;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b00));
    repeat (10) step();
    sw_n = 2'b11;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b11));
    lq_n.push_back(mk(e0 + 6, 8'h01));
    repeat (10) step();

    // Reset in the middle of a 01 -> 11 debounce
    sw_n = 2'b01;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b01));
    lq_n.push_back(mk(e0 + 6, 8'h00));
    repeat (10) step();
    sw_n = 2'b11;
    repeat (4) step();
    chk("mid_stable_pre", 8'(stable_n), 8'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stable", 8'(stable_n), 8'h00);
    chk("mid_rst_led", 8'(led_n), 8'h00);
    chk("mid_rst_changed", 8'(chg_n), 8'h00);
    repeat (2) step();
    rst_n = 1'b1;
    e0 = cyc + 1;
    sq_n.push_back(mk(e0 + 5, 8'b11));
    lq_n.push_back(mk(e0 + 6, 8'h01));
    repeat (10) step();

    // Wide build, XOR parity
    sw_w = 4'b1011;
    e0 = cyc + 1;
    sq_w.push_back(mk(e0 + 2, 8'b1011));
    lq_w.push_back(mk(e0 + 3, 8'h01));
    repeat (6) step();
    sw_w = 4'b1111;
    e0 = cyc + 1;
    sq_w.push_back(mk(e0 + 2, 8'b1111));
    lq_w.push_back(mk(e0 + 3, 8'h00));
    repeat (6) step();

    chk("drain_sq_n", 8'(sq_n.size()), 8'h00);
    chk("drain_lq_n", 8'(lq_n.size()), 8'h00);
    chk("drain_sq_w", 8'(sq_w.size()), 8'h00);
    chk("drain_lq_w", 8'(lq_w.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised successor to the single two-input AND gate driven by switches into an LED. It takes `N_IN` raw mechanical switch inputs, synchronises and debounces each one, and combines them with a runtime-selectable gate function. It drives a registered LED output plus a one-cycle change pulse. It sits between the board switch bank and the LED/indicator logic of the lab top level.

## Interface

**Parameters**
- `N_IN`, default 2: number of switch inputs; legal range 2..8.
- `DEB_CYCLES`, default 4: consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..255.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sw_i`, in, `N_IN`: raw asynchronous switch levels.
- `op_i`, in, 3: gate select, sampled every cycle.
- `stable_o`, out, `N_IN`: debounced switch levels. Registered.
- `led_o`, out, 1: gate result. Registered.
- `changed_o`, out, 1: one-cycle pulse, high in the cycle after `led_o` takes a new value.

## Operation

**Per input**
- Two-flop synchroniser produces `sync2`.
- A counter of width `clog2(DEB_CYCLES+1)` tracks mismatches.
- Counter update, each edge:
  - If `sync2 == stable`: clear the counter.
  - Else if `count == DEB_CYCLES-1`: load `stable` from `sync2` and clear the counter.
  - Else: increment the counter.
- A mismatch lasting fewer than `DEB_CYCLES` consecutive cycles never reaches `stable_o`.

**Gate functions** (applied over all `N_IN` bits of `stable_o`)
- 000 AND
- 001 OR
- 010 XOR (odd parity)
- 011 NAND
- 100 NOR
- 101 XNOR
- 110 BUF, which passes `stable_o[0]`
- 111 constant 0

**Output register**
- `led_o` is loaded each edge with f(`op_i`, `stable_o`).
- `changed_o` is loaded with (new `led_o` != old `led_o`).
- An `op_i` change alone is a legal cause of `changed_o`.

**Reset** (`rst_n` = 0)
- Synchronisers, counters, `stable_o`, `led_o` and `changed_o` all go to 0 immediately.
- First edge after reset release: `led_o` is computed from `stable_o` = 0. For example, with NAND, `led_o` becomes 1 and `changed_o` pulses.

**Reset asserted mid-debounce**
- A partial count is discarded.
- The input must be stable for the full `DEB_CYCLES + 2` cycles again after release.

## Timing

- Reference point: `sw_i[k]` changes before edge 0 and then holds.
- `sync2` becomes the new level at edge 1.
- `stable_o[k]` updates at edge `DEB_CYCLES+1`.
- `led_o` updates at edge `DEB_CYCLES+2`.
- `changed_o` is high for exactly one cycle, from edge `DEB_CYCLES+2` to edge `DEB_CYCLES+3`.
- Latency from `op_i` to `led_o` is 1 cycle.
- Inputs debounce independently. Two inputs changing at the same edge update `stable_o` together and produce a single `changed_o` pulse.
- Bounce that returns to the old level before the count completes clears the counter.

## Structure

- **Shared package** holds:
  - the 3-bit op encoding constants (`OP_AND` … `OP_ZERO`);
  - a function for the gate reduction, reused by future ALU labs.
- **Sub-module** `switch_debounce`: one instance per input, generated `N_IN` times.
  - Contains the synchroniser, the counter and `stable`.
  - Parameter: `DEB_CYCLES`.
- **Top level** contains only the generate loop, the reduction and the output register.

## Test plan

All scenarios use `N_IN`=2 and `DEB_CYCLES`=4 unless stated otherwise.

1. **Reset:** hold `rst_n`=0 with `sw_i`=11 and `op_i`=AND → all outputs 0. Release reset → `stable_o`=11 at edge 5, `led_o`=1 at edge 6, `changed_o` is a single pulse.
2. **Bounce rejection:** start with `sw_i`=00 and OR, stable. Toggle `sw_i[0]` high for 3 cycles, then low → `stable_o`, `led_o` and `changed_o` never change.
3. **Truth table:** with `sw_i` settled at 10, step `op_i` 000→111 one value per cycle. Required `led_o` one cycle later: 0,1,1,1,0,0,0,0. `changed_o` pulses on each transition.
4. **Simultaneous change:** start at `sw_i`=00 with AND (`led_o`=0). Switch to `sw_i`=11 in one step → `led_o`=1 at edge 6 and exactly one `changed_o` pulse.
5. **Reset mid-debounce:** start `sw_i` 01→11 at edge 0. Pulse `rst_n` low at edge 3 → all outputs 0 immediately. After release, `stable_o`=11 is reached a full 5 edges later.
6. **Wider build** (`N_IN`=4, `DEB_CYCLES`=1): with `sw_i`=1011, XOR → `led_o`=1 at edge 3. Then set `sw_i`=1111 → `led_o`=0 at edge 3 after that change.
